// File: rtl/iob_regfile_rd_stream_pkg.sv
// Shared definitions for the register file streaming read engine.
// Holds the 2-bit FSM state encoding used by iob_regfile_rd_stream.
package iob_regfile_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

endpackage

// File: rtl/iob_regfile_rd_stream.sv
// Streaming read engine: on start, walks a contiguous wrap-around address
// range of an external register file through its combinational read port
// and emits each word on a valid/ready stream with a last marker.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a burst (sampled only when idle)
//   first_addr, count   burst start address and length (0..2**ADDR_W)
//   busy, done          engine active / one-cycle completion pulse
//   rf_addr, rf_r_data  register file read port (data combinational)
//   m_valid, m_ready    output stream handshake
//   m_data, m_last      output word and final-word marker
module iob_regfile_rd_stream
  import iob_regfile_rd_stream_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_r_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;

  // Read address comes straight from the counter register, never from inputs.
  assign rf_addr = addr;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr      <= first_addr;
              remaining <= count;
              state     <= ST_RUN;
            end else begin
              // Empty burst completes immediately with no beats.
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Load when the output register is empty or being drained this cycle.
          if (!m_valid || m_ready) begin
            m_data    <= rf_r_data;
            m_valid   <= 1'b1;
            m_last    <= (remaining == (ADDR_W+1)'(1));
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) state <= ST_LAST;
          end
        end
        ST_LAST: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_regfile_rd_stream.sv
module tb_iob_regfile_rd_stream;

  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW:0]   count;
  logic          busy, done;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_r_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  logic [DW-1:0] rf [0:3];
  assign rf_r_data = rf[rf_addr];

  iob_regfile_rd_stream #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .count(count),
    .busy(busy), .done(done), .rf_addr(rf_addr), .rf_r_data(rf_r_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int beats, first_beat, last_cyc, done_cyc;
  logic [DW:0] sb [$];
  logic        hold_pending;
  logic [DW:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Observe the current cycle, then advance one clock edge.
  task automatic tick();
    logic [DW:0] e;
    if (done) begin
      done_cyc = cyc;
      check("busy_at_done", busy, 1'b0);
    end
    if (m_valid && m_last) last_cyc = cyc;
    if (m_valid && m_ready) begin
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_data", m_data, e[DW-1:0]);
        check("beat_last", m_last, e[DW]);
      end
      if (beats == 0) first_beat = cyc;
      beats++;
    end
    hold_pending = m_valid && !m_ready;
    held = {m_last, m_data};
    @(posedge clk);
    #1;
    cyc++;
    if (hold_pending) begin
      check("stall_valid", m_valid, 1'b1);
      check("stall_hold", {m_last, m_data}, held);
    end
  endtask

  task automatic burst(input logic [AW-1:0] fa, input logic [AW:0] cnt, input bit stall,
                       input bit inject, input int exp_done, input bit rst_after2);
    int n, guard;
    logic [AW-1:0] a;
    beats = 0; first_beat = -1; last_cyc = -1; done_cyc = -1;
    for (int unsigned i = 0; i < cnt; i++) begin
      a = fa + AW'(i);
      sb.push_back({(i == cnt - 1), 32'h100 + DW'(a)});
    end
    first_addr = fa; count = cnt; start = 1'b1; m_ready = 1'b1;
    n = cyc;
    tick();
    start = 1'b0;
    if (cnt != 0) begin
      check("busy_n1", busy, 1'b1);
      check("rf_addr_n1", rf_addr, fa);
    end
    guard = 0;
    while (done_cyc < 0 && guard < 40) begin
      m_ready = stall ? (((cyc - n) % 2) == 1) : 1'b1;
      start = inject && (cyc == n + 2);
      first_addr = inject ? 2'd1 : fa;
      tick();
      start = 1'b0;
      guard++;
      if (rst_after2 && beats == 2) begin
        rst = 1'b1;
        #1;
        check("rst_valid", m_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_no_done", done, 1'b0);
        rst = 1'b0;
        cyc++;
        return;
      end
    end
    check("done_offset", done_cyc - n, exp_done);
    check("beat_count", beats, cnt);
    check("sb_empty", sb.size(), 0);
    if (cnt != 0 && !stall) begin
      check("first_beat", first_beat - n, 2);
      check("last_cycle", last_cyc - n, cnt + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 32'h100 + i;
    rst = 1'b1; start = 1'b0; first_addr = '0; count = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy0", busy, 1'b0);
    check("rst_done0", done, 1'b0);
    check("rst_valid0", m_valid, 1'b0);
    check("rst_last0", m_last, 1'b0);
    check("rst_data0", m_data, 32'h0);
    check("rst_addr0", rf_addr, 2'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    burst(2'd0, 3'd4, 1'b0, 1'b0, 6, 1'b0);   // basic
    burst(2'd3, 3'd3, 1'b0, 1'b0, 5, 1'b0);   // wrap 3,0,1
    burst(2'd0, 3'd4, 1'b1, 1'b0, 10, 1'b0);  // backpressure
    burst(2'd1, 3'd0, 1'b0, 1'b0, 1, 1'b0);   // empty burst
    check("cnt0_no_valid", beats, 0);
    burst(2'd2, 3'd4, 1'b0, 1'b0, 6, 1'b0);   // full wrap from 2
    burst(2'd0, 3'd4, 1'b0, 1'b1, 6, 1'b0);   // start while busy
    burst(2'd0, 3'd4, 1'b0, 1'b0, 6, 1'b1);   // reset after 2nd beat
    burst(2'd0, 3'd4, 1'b0, 1'b0, 6, 1'b0);   // fresh basic burst
    rf[1] = 32'h0000_0101;
    burst(2'd1, 3'd1, 1'b0, 1'b0, 3, 1'b0);   // single word

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iob_regfile_rd_stream.md
# iob_regfile_rd_stream

Streaming read engine for the single-port register file family. On a start command it walks a contiguous, wrap-around address range of an external register file, using its combinational read port, and emits each word on a valid/ready output stream with a last marker. It is the drain side of the register file: software or a control FSM fills the file through the write port, and this block reads it out to a downstream consumer.

## Interface
Parameters:
- ADDR_W, 2, register file address width; depth is 2**ADDR_W.
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a burst; sampled only in IDLE.
- first_addr  in  ADDR_W  first address of the burst; latched on an accepted start.
- count  in  ADDR_W+1  number of words, 0..2**ADDR_W; latched on an accepted start.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- rf_addr  out  ADDR_W  address to the register file read port.
- rf_r_data  in  DATA_W  register file read data, combinational from rf_addr in the same cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- m_data  out  DATA_W  output word.
- m_last  out  1  marks the final word of the burst; qualified by m_valid.

## Operation
- The FSM has three states: IDLE, RUN and LAST.
- Reset values: state=IDLE, address counter=0, remaining=0, busy=0, done=0, m_valid=0, m_last=0, m_data=0.
- rf_addr is driven directly from the address counter register. It does not depend combinationally on any input.
- IDLE:
  - If start && count!=0: latch addr=first_addr and remaining=count, then go to RUN.
  - If start && count==0: stay in IDLE and pulse done next cycle. No beats are emitted.
- Load condition: load = (state==RUN) && (!m_valid || m_ready).
- On load:
  - m_data <= rf_r_data and m_valid <= 1.
  - m_last <= (remaining==1).
  - addr <= addr+1, modulo 2**ADDR_W, so the burst wraps from the top address to 0.
  - remaining <= remaining-1.
  - If remaining==1, go to LAST.
- RUN with m_valid && !m_ready: no load. m_data, m_last and addr hold.
- LAST: holds the final word. On m_ready:
  - Clear m_valid and m_last.
  - Pulse done.
  - Return to IDLE.
- A start asserted while busy is ignored. It is not queued.
- Stream rule: once m_valid is high, m_valid, m_data and m_last stay stable until the handshake.
- Data coherence: each word reflects the register file contents in the cycle it is loaded. A write to an address in the cycle before its load is visible in the stream.
- Reset asserted mid-burst returns all state and outputs to their reset values immediately. No done pulse is issued.

## Timing
- start high in cycle N (IDLE):
  - Cycle N+1: busy=1, state=RUN, rf_addr=first_addr.
  - Cycle N+2: m_valid=1, m_data = word read in cycle N+1.
- Throughput is 1 word/cycle while m_ready is held high.
- With count=C and m_ready=1 throughout:
  - Beats occur in cycles N+2..N+C+1.
  - m_last is high in cycle N+C+1.
  - done is high in cycle N+C+2, the same cycle busy returns to 0.
- Each low cycle of m_ready stretches the burst by exactly one cycle.
- count==0: done is high in cycle N+1; busy stays 0.
- A new start is accepted in the cycle done is high, since the block is back in IDLE.

## Structure
- Shared package: the state encoding constants for IDLE, RUN and LAST (2 bits).
- No sub-module. The address counter, remaining counter and single output register stay inline.
- The block instantiates no register file. It connects to one at system level.

## Test plan
- Basic burst: regfile[i]=i+0x100 for ADDR_W=2, start with first_addr=0, count=4, m_ready=1.
  - Expected: 0x100..0x103 on consecutive cycles N+2..N+5, m_last on 0x103, done at N+6.
- Wrap-around: first_addr=3, count=3.
  - Expected: addresses 3,0,1 give 0x103, 0x100, 0x101; m_last on 0x101.
- Backpressure: count=4, m_ready toggling 1,0,1,0.
  - Expected: m_data and m_last stable during every stall.
  - Expected: all four words in order, each exactly once; done 4 cycles later than the unstalled case.
- Edge counts:
  - count=0: done at N+1, no m_valid.
  - count=4 with first_addr=2: wraps and stops after 4 beats.
  - start while busy: ignored, no extra beats.
- Reset mid-burst: assert rst after the 2nd beat.
  - Expected: m_valid, busy and done go to 0 immediately.
  - Expected: after release, a fresh start reproduces the full basic burst.
